// File: rtl/fetch_stage_bram_pkg.sv
// Shared constants for the RV32I core front end.
package riscv_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          IMEM_WORD_LSB = 2;

endpackage

// File: rtl/fetch_stage_bram_if_id_reg.sv
// IF/ID pipeline register: flush beats stall; a flushed slot is a NOP bubble with ValidD=0.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       instr_f,
  input  logic [XLEN_P-1:0] pc_f,
  input  logic [XLEN_P-1:0] pc_plus4_f,
  output logic [31:0]       instr_d,
  output logic [XLEN_P-1:0] pc_d,
  output logic [XLEN_P-1:0] pc_plus4_d,
  output logic              valid_d
);

  // Load, hold or bubble the Decode-stage slot.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (!stall) begin
      instr_d    <= instr_f;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage_bram.sv
// Fetch stage with a synchronous-read instruction BRAM. The next PC is presented to
// the BRAM a cycle early, so imem_rdata always corresponds to PCF.
module fetch_stage_bram
  import riscv_pkg::*;
#(
  parameter int              XLEN_P   = XLEN,
  parameter int              IMEM_AW  = 10,
  parameter logic [XLEN_P-1:0] RESET_PC_P = XLEN_P'(RESET_PC),
  parameter int              CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               FlushD,
  input  logic               PcSrcE,
  input  logic [XLEN_P-1:0]  PCTargetE,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        InstrD,
  output logic [XLEN_P-1:0]  PCD,
  output logic [XLEN_P-1:0]  PCPlus4D,
  output logic               ValidD,
  output logic [XLEN_P-1:0]  PCF,
  output logic [CNT_W-1:0]   cnt_fetch,
  output logic [CNT_W-1:0]   cnt_stall,
  output logic [CNT_W-1:0]   cnt_flush
);

  localparam int                 AHI     = IMEM_AW + IMEM_WORD_LSB - 1;
  localparam logic [XLEN_P-1:0]  PC_STEP = XLEN_P'(4);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  logic [XLEN_P-1:0] pc_sel;
  logic [XLEN_P-1:0] pc_plus4_f;
  logic              unused_tgt_lsb;

  // The target is word-aligned by construction; its low bits are dropped.
  assign unused_tgt_lsb = &{1'b0, PCTargetE[1:0]};
  assign pc_plus4_f     = PCF + PC_STEP;

  // Next-PC select: redirect beats stall beats sequential fetch.
  always_comb begin
    pc_sel = pc_plus4_f;
    if (PcSrcE)      pc_sel = {PCTargetE[XLEN_P-1:2], 2'b00};
    else if (stallF) pc_sel = PCF;
  end

  // During reset the BRAM is primed with RESET_PC so its word is ready at release.
  assign imem_addr = reset ? pc_sel[AHI:IMEM_WORD_LSB] : RESET_PC_P[AHI:IMEM_WORD_LSB];
  assign imem_en   = 1'b1;

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (!reset) PCF <= RESET_PC_P;
    else        PCF <= pc_sel;
  end

  if_id_reg #(.XLEN_P(XLEN_P)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .stall      (stallD),
    .flush      (FlushD),
    .instr_f    (imem_rdata),
    .pc_f       (PCF),
    .pc_plus4_f (pc_plus4_f),
    .instr_d    (InstrD),
    .pc_d       (PCD),
    .pc_plus4_d (PCPlus4D),
    .valid_d    (ValidD)
  );

  // Saturating performance counters for loads, stalls and flushes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_fetch <= '0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      if (!FlushD && !stallD && cnt_fetch != '1) cnt_fetch <= cnt_fetch + CNT_ONE;
      if (!FlushD && stallD && cnt_stall != '1)  cnt_stall <= cnt_stall + CNT_ONE;
      if (FlushD && cnt_flush != '1)             cnt_flush <= cnt_flush + CNT_ONE;
    end
  end

endmodule
